dl_router: RTL and testbench

DL_ROUTER -- requirements
Module: dl_router

---
 rtl/dl_router.sv | 199 +++++++++++++++++++
 tb/tb_dl_router.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_router.sv
// -----------------------------------------------------------------------------
// dl_router
//   Routes a data_io ROM download into per-region write strobes and keeps the
//   game core in reset while a download runs and for RST_HOLD cycles after.
//
// Ports
//   clk_sys      in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   ioctl_downl  in   download-active level
//   ioctl_index  in   download slot index (only DL_INDEX is accepted)
//   ioctl_wr     in   one-cycle byte-valid strobe
//   ioctl_addr   in   byte address [24:0]
//   ioctl_dout   in   byte data
//   dl_addr      out  region-local write address (registered)
//   dl_data      out  write data (registered)
//   prog_we      out  program ROM strobe, 0x0000-0x3FFF
//   chr1_we      out  char ROM 1 strobe,  0x4000-0x4FFF
//   chr2_we      out  char ROM 2 strobe,  0x5000-0x5FFF
//   prom_we      out  colour PROM strobe, 0x6000-0x61FF
//   core_reset   out  reset to the game core (high in LOAD and HOLD)
//   dl_busy      out  high while in LOAD
//   dl_bytes     out  saturating count of accepted bytes
//   dl_err       out  sticky out-of-range address flag
//   dbg_state    out  current FSM state (IDLE=0, LOAD=1, HOLD=2)
// -----------------------------------------------------------------------------
module dl_router #(
  parameter int         RST_HOLD = 16,
  parameter logic [7:0] DL_INDEX = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        prog_we,
  output logic        chr1_we,
  output logic        chr2_we,
  output logic        prom_we,
  output logic        core_reset,
  output logic        dl_busy,
  output logic [16:0] dl_bytes,
  output logic        dl_err,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int             CW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CW-1:0]  HOLD_INIT = CW'(RST_HOLD - 1);
  localparam logic [16:0]    BYTES_MAX = 17'h1FFFF;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          downl_q;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  // we bit order: 0 prog, 1 chr1, 2 chr2, 3 prom
  logic [3:0]    we_q, we_d;
  logic          core_rst_q, core_rst_d;
  logic          busy_q, busy_d;
  logic [16:0]   bytes_q, bytes_d;
  logic          err_q, err_d;

  logic        idx_match;
  logic        start;
  logic        accept;
  logic [15:0] lo_addr;
  logic        out_of_range;
  logic [3:0]  region_we;
  logic [15:0] region_base;

  assign idx_match = (ioctl_index == DL_INDEX);
  // Rising edge of downl only; downl_q resets to 1 so a download already
  // running when reset releases is never mistaken for a new one.
  assign start     = ioctl_downl && !downl_q && idx_match;
  // The byte coinciding with the downl fall is dropped because downl must be 1.
  assign accept    = (state_q == LOAD) && ioctl_wr && ioctl_downl && idx_match;

  assign lo_addr      = ioctl_addr[15:0];
  assign out_of_range = (|ioctl_addr[24:16]) || (lo_addr >= 16'h6200);

  always_comb begin
    region_we   = 4'b0000;
    region_base = 16'h0000;
    if (lo_addr < 16'h4000) begin
      region_we   = 4'b0001;
      region_base = 16'h0000;
    end else if (lo_addr < 16'h5000) begin
      region_we   = 4'b0010;
      region_base = 16'h4000;
    end else if (lo_addr < 16'h6000) begin
      region_we   = 4'b0100;
      region_base = 16'h5000;
    end else begin
      region_we   = 4'b1000;
      region_base = 16'h6000;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 4'b0000;
    bytes_d = bytes_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          bytes_d = 17'd0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (!ioctl_downl) begin
          state_d = HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      HOLD: begin
        // A fresh download restarts LOAD without waiting out the hold count.
        if (start) begin
          state_d = LOAD;
          bytes_d = 17'd0;
          err_d   = 1'b0;
        end else if (hold_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (bytes_q != BYTES_MAX) bytes_d = bytes_q + 17'd1;
      if (out_of_range) begin
        err_d = 1'b1;
      end else begin
        we_d   = region_we;
        addr_d = lo_addr - region_base;
        data_d = ioctl_dout;
      end
    end

    // Derived from the next state so these registered outputs track the FSM
    // on the same edge; core_reset falls RST_HOLD edges after LOAD exits.
    busy_d     = (state_d == LOAD);
    core_rst_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= HOLD;
      hold_q     <= HOLD_INIT;
      downl_q    <= 1'b1;
      addr_q     <= 16'h0000;
      data_q     <= 8'h00;
      we_q       <= 4'b0000;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      bytes_q    <= 17'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      downl_q    <= ioctl_downl;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      bytes_q    <= bytes_d;
      err_q      <= err_d;
    end
  end

  assign dl_addr    = addr_q;
  assign dl_data    = data_q;
  assign prog_we    = we_q[0];
  assign chr1_we    = we_q[1];
  assign chr2_we    = we_q[2];
  assign prom_we    = we_q[3];
  assign core_reset = core_rst_q;
  assign dl_busy    = busy_q;
  assign dl_bytes   = bytes_q;
  assign dl_err     = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dl_router.sv
// -----------------------------------------------------------------------------
// tb_dl_router
//   Directed self-checking bench for dl_router (RST_HOLD=16, DL_INDEX=0).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_dl_router;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_downl = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        prog_we, chr1_we, chr2_we, prom_we;
  logic        core_reset, dl_busy, dl_err;
  logic [16:0] dl_bytes;
  logic [1:0]  dbg_state;
  logic [3:0]  we_v;

  int n_checks = 0;
  int n_errors = 0;

  assign we_v = {prom_we, chr2_we, chr1_we, prog_we};

  dl_router #(.RST_HOLD(16), .DL_INDEX(8'h00)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_downl(ioctl_downl),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .dl_addr(dl_addr), .dl_data(dl_data),
    .prog_we(prog_we), .chr1_we(chr1_we), .chr2_we(chr2_we), .prom_we(prom_we),
    .core_reset(core_reset), .dl_busy(dl_busy), .dl_bytes(dl_bytes),
    .dl_err(dl_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad;
    step();  // one cycle of reset
    n_checks++;
    if ({core_reset, dl_busy, dl_err, we_v} !== 7'b1000000) begin
      n_errors++;
      $display("FAIL reset_flags: got core_reset/busy/err/we=%b want 1000000",
               {core_reset, dl_busy, dl_err, we_v});
    end
    n_checks++;
    if (dbg_state !== ST_HOLD || dl_bytes !== 17'd0 || dl_addr !== 16'h0 || dl_data !== 8'h0) begin
      n_errors++;
      $display("FAIL reset_regs: state=%0d bytes=%0h addr=%0h data=%0h want 2/0/0/0",
               dbg_state, dl_bytes, dl_addr, dl_data);
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (core_reset !== 1'b1 || we_v !== 4'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL reset_hold: %0d early release/strobe cycles, want 0", bad);
    end
    step();
    n_checks++;
    if (core_reset !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL reset_release: core_reset=%b state=%0d want 0/0", core_reset, dbg_state);
    end
  endtask

  task automatic test_download();
    logic [24:0] a_tab [4] = '{25'h0000, 25'h4001, 25'h5FFF, 25'h61FF};
    logic [7:0]  d_tab [4] = '{8'hAA, 8'h55, 8'h12, 8'h0F};
    logic [15:0] ea_tab[4] = '{16'h0000, 16'h0001, 16'h0FFF, 16'h01FF};
    logic [3:0]  ew_tab[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    ioctl_index = 8'h00;
    ioctl_downl = 1'b1;
    step();
    n_checks++;
    if (dbg_state !== ST_LOAD || dl_busy !== 1'b1 || core_reset !== 1'b1 || dl_bytes !== 17'd0) begin
      n_errors++;
      $display("FAIL dl_start: state=%0d busy=%b core_reset=%b bytes=%0d want 1/1/1/0",
               dbg_state, dl_busy, core_reset, dl_bytes);
    end
    // back-to-back writes, one per region
    for (int i = 0; i < 4; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = a_tab[i];
      ioctl_dout = d_tab[i];
      step();
      n_checks++;
      if (we_v !== ew_tab[i] || dl_addr !== ea_tab[i] || dl_data !== d_tab[i]) begin
        n_errors++;
        $display("FAIL dl_byte%0d: we=%b addr=%h data=%h want %b/%h/%h",
                 i, we_v, dl_addr, dl_data, ew_tab[i], ea_tab[i], d_tab[i]);
      end
    end
    ioctl_wr = 1'b0;
    step();
    n_checks++;
    if (we_v !== 4'b0 || dl_bytes !== 17'd4 || dl_err !== 1'b0) begin
      n_errors++;
      $display("FAIL dl_after: we=%b bytes=%0d err=%b want 0000/4/0", we_v, dl_bytes, dl_err);
    end
  endtask

  task automatic test_out_of_range();
    int bad;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h6200;
    ioctl_dout = 8'h77;
    step();
    n_checks++;
    if (we_v !== 4'b0 || dl_err !== 1'b1 || dl_bytes !== 17'd5) begin
      n_errors++;
      $display("FAIL oor_6200: we=%b err=%b bytes=%0d want 0000/1/5", we_v, dl_err, dl_bytes);
    end
    ioctl_addr = 25'h010000;
    ioctl_dout = 8'h66;
    step();
    n_checks++;
    if (we_v !== 4'b0 || dl_bytes !== 17'd6) begin
      n_errors++;
      $display("FAIL oor_hi: we=%b bytes=%0d want 0000/6", we_v, dl_bytes);
    end
    // last wr coincides with the downl fall: must be dropped
    ioctl_addr  = 25'h0002;
    ioctl_dout  = 8'h99;
    ioctl_downl = 1'b0;
    step();
    ioctl_wr = 1'b0;
    n_checks++;
    if (we_v !== 4'b0 || dl_bytes !== 17'd6 || dbg_state !== ST_HOLD || dl_busy !== 1'b0 || core_reset !== 1'b1) begin
      n_errors++;
      $display("FAIL coincide: we=%b bytes=%0d state=%0d busy=%b core_reset=%b want 0000/6/2/0/1",
               we_v, dl_bytes, dbg_state, dl_busy, core_reset);
    end
    bad = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (core_reset !== 1'b1) bad++;
    end
    step();
    n_checks++;
    if (bad != 0 || core_reset !== 1'b0 || dbg_state !== ST_IDLE || dl_err !== 1'b1) begin
      n_errors++;
      $display("FAIL hold16: early=%0d core_reset=%b state=%0d err=%b want 0/0/0/1",
               bad, core_reset, dbg_state, dl_err);
    end
    ioctl_downl = 1'b1;
    step();
    n_checks++;
    if (dl_err !== 1'b0 || dl_bytes !== 17'd0 || dbg_state !== ST_LOAD) begin
      n_errors++;
      $display("FAIL err_clear: err=%b bytes=%0d state=%0d want 0/0/1", dl_err, dl_bytes, dbg_state);
    end
  endtask

  task automatic test_hold_restart();
    int bad;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h4FFF;
    ioctl_dout = 8'h3C;
    step();
    ioctl_wr = 1'b0;
    n_checks++;
    if (we_v !== 4'b0010 || dl_addr !== 16'h0FFF || dl_data !== 8'h3C) begin
      n_errors++;
      $display("FAIL chr1_top: we=%b addr=%h data=%h want 0010/0fff/3c", we_v, dl_addr, dl_data);
    end
    ioctl_downl = 1'b0;
    step();  // HOLD entered
    bad = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (core_reset !== 1'b1 || dbg_state !== ST_HOLD) bad++;
    end
    ioctl_downl = 1'b1;
    step();  // 5 cycles into HOLD
    n_checks++;
    if (bad != 0 || dbg_state !== ST_LOAD || core_reset !== 1'b1 || dl_busy !== 1'b1 || dl_bytes !== 17'd0) begin
      n_errors++;
      $display("FAIL hold_restart: bad=%0d state=%0d core_reset=%b busy=%b bytes=%0d want 0/1/1/1/0",
               bad, dbg_state, core_reset, dl_busy, dl_bytes);
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0010;
    ioctl_dout = 8'h01;
    step();
    n_checks++;
    if (we_v !== 4'b0001 || dl_addr !== 16'h0010 || dl_data !== 8'h01) begin
      n_errors++;
      $display("FAIL restart_b0: we=%b addr=%h data=%h want 0001/0010/01", we_v, dl_addr, dl_data);
    end
    ioctl_addr = 25'h6000;
    ioctl_dout = 8'h02;
    step();
    ioctl_wr    = 1'b0;
    ioctl_downl = 1'b0;
    n_checks++;
    if (we_v !== 4'b1000 || dl_addr !== 16'h0000 || dl_data !== 8'h02) begin
      n_errors++;
      $display("FAIL restart_b1: we=%b addr=%h data=%h want 1000/0000/02", we_v, dl_addr, dl_data);
    end
    step();  // HOLD entered
    for (int i = 1; i <= 16; i++) step();
    n_checks++;
    if (dbg_state !== ST_IDLE || core_reset !== 1'b0 || dl_bytes !== 17'd2) begin
      n_errors++;
      $display("FAIL restart_end: state=%0d core_reset=%b bytes=%0d want 0/0/2", dbg_state, core_reset, dl_bytes);
    end
  endtask

  task automatic test_wrong_index();
    int bad;
    ioctl_index = 8'h01;
    ioctl_downl = 1'b1;
    bad = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'hF0;
      step();
      if (we_v !== 4'b0 || dbg_state !== ST_IDLE || core_reset !== 1'b0) bad++;
    end
    ioctl_wr = 1'b0;
    n_checks++;
    if (bad != 0 || dl_bytes !== 17'd2 || dl_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL wrong_index: bad=%0d bytes=%0d busy=%b want 0/2/0", bad, dl_bytes, dl_busy);
    end
    ioctl_downl = 1'b0;
    ioctl_index = 8'h00;
    step();
  endtask

  task automatic test_reset_mid_download();
    int bad;
    ioctl_downl = 1'b1;
    step();
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0005;
    ioctl_dout = 8'h11;
    step();
    n_checks++;
    if (we_v !== 4'b0001 || dl_addr !== 16'h0005 || dl_data !== 8'h11) begin
      n_errors++;
      $display("FAIL mid_pre: we=%b addr=%h data=%h want 0001/0005/11", we_v, dl_addr, dl_data);
    end
    reset      = 1'b1;
    ioctl_addr = 25'h0006;
    ioctl_dout = 8'h22;
    step();
    reset = 1'b0;
    n_checks++;
    if (we_v !== 4'b0 || dbg_state !== ST_HOLD || dl_bytes !== 17'd0 || dl_addr !== 16'h0 ||
        dl_data !== 8'h0 || core_reset !== 1'b1 || dl_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: we=%b state=%0d bytes=%0d addr=%h data=%h core_reset=%b busy=%b",
               we_v, dbg_state, dl_bytes, dl_addr, dl_data, core_reset, dl_busy);
    end
    bad = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (we_v !== 4'b0 || core_reset !== 1'b1) bad++;
    end
    step();
    n_checks++;
    if (bad != 0 || core_reset !== 1'b0 || dbg_state !== ST_IDLE || we_v !== 4'b0) begin
      n_errors++;
      $display("FAIL mid_release: bad=%0d core_reset=%b state=%0d we=%b want 0/0/0/0000",
               bad, core_reset, dbg_state, we_v);
    end
    step();  // downl still high, wr still active: no start
    n_checks++;
    if (dbg_state !== ST_IDLE || we_v !== 4'b0 || dl_bytes !== 17'd0) begin
      n_errors++;
      $display("FAIL mid_nostart: state=%0d we=%b bytes=%0d want 0/0000/0", dbg_state, we_v, dl_bytes);
    end
    ioctl_wr    = 1'b0;
    ioctl_downl = 1'b0;
    step();
    ioctl_downl = 1'b1;
    step();
    n_checks++;
    if (dbg_state !== ST_LOAD || dl_busy !== 1'b1 || core_reset !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reenter: state=%0d busy=%b core_reset=%b want 1/1/1", dbg_state, dl_busy, core_reset);
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h5000;
    ioctl_dout = 8'hE1;
    step();
    ioctl_wr    = 1'b0;
    ioctl_downl = 1'b0;
    n_checks++;
    if (we_v !== 4'b0100 || dl_addr !== 16'h0000 || dl_data !== 8'hE1 || dl_bytes !== 17'd1) begin
      n_errors++;
      $display("FAIL mid_chr2: we=%b addr=%h data=%h bytes=%0d want 0100/0000/e1/1",
               we_v, dl_addr, dl_data, dl_bytes);
    end
    step();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_download();
    test_out_of_range();
    test_hold_restart();
    test_wrong_index();
    test_reset_mid_download();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
